// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: instruction field positions,
// opcode encodings and the FSM state encoding.
package cpu_pkg;

  // Instruction word layout (16 bits):
  //   [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt / imm4, [7:0] target
  localparam int INSTR_W = 16;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 0;
  localparam int IMM_W   = 4;
  localparam int TGT_W   = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  // Opcodes 1..7 produce a register write-back; everything else does not.
  function automatic logic op_writes_reg(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multicycle CPU.
// Ports:
//   op  - instruction opcode
//   a   - rs operand
//   b   - rt operand
//   imm - 4-bit immediate (LDI)
//   y   - result, modulo 2^DATA_W (carries and borrows discarded)
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_LDI:  y = DATA_W'(imm);
      OP_MOV:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Four-cycle-per-instruction CPU: FETCH, DECODE, EXECUTE, WRITEBACK.
// Instruction memory is loaded through the imem_* port while the core is
// not busy; execution begins at pc 0 on start from IDLE or HALT.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start         - begin execution at pc 0 (IDLE/HALT only)
//   imem_we       - instruction-memory write strobe (ignored while busy)
//   imem_addr     - instruction-memory write address
//   imem_wdata    - instruction word to store
//   busy          - high in FETCH/DECODE/EXECUTE/WRITEBACK
//   halted        - high in HALT
//   pc            - program counter
//   result        - last register write-back value
//   result_valid  - one-cycle pulse per register write-back
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 4,
  parameter int IMEM_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [INSTR_W-1:0]            imem_wdata,
  output logic                          busy,
  output logic                          halted,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic [DATA_W-1:0]             result,
  output logic                          result_valid
);

  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam int RI_W = $clog2(NUM_REGS);

  logic [2:0]         state;
  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0]  regs [NUM_REGS];

  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  opa;
  logic [DATA_W-1:0]  opb;
  logic [DATA_W-1:0]  opd;
  logic [DATA_W-1:0]  alu_y;
  logic [DATA_W-1:0]  alu_q;
  logic               take_q;

  logic [3:0]       op;
  logic [RI_W-1:0]  rd_idx;
  logic [RI_W-1:0]  rs_idx;
  logic [RI_W-1:0]  rt_idx;
  logic [PC_W-1:0]  tgt;
  logic [IMM_W-1:0] imm;

  // Register indices and the jump target use only the low bits of their
  // fields, so some instruction bits are legitimately unused.
  logic unused_ir;

  assign op        = ir[OP_MSB:OP_LSB];
  assign rd_idx    = ir[RD_LSB +: RI_W];
  assign rs_idx    = ir[RS_LSB +: RI_W];
  assign rt_idx    = ir[RT_LSB +: RI_W];
  assign tgt       = ir[PC_W-1:0];
  assign imm       = ir[IMM_W-1:0];
  assign unused_ir = ^ir;

  assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                  (state == S_EXECUTE) || (state == S_WRITEBACK);
  assign halted = (state == S_HALT);

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (op),
    .a   (opa),
    .b   (opb),
    .imm (imm),
    .y   (alu_y)
  );

  // Instruction memory: loadable only while the core is idle or halted,
  // never cleared by reset.
  always_ff @(posedge clk) begin
    if (imem_we && !busy) begin
      imem[imem_addr] <= imem_wdata;
    end
  end

  // Datapath registers. Their contents are only consumed in the state after
  // they are loaded, so they need no reset.
  always_ff @(posedge clk) begin
    case (state)
      S_FETCH: begin
        ir <= imem[pc];
      end
      S_DECODE: begin
        opa <= regs[rs_idx];
        opb <= regs[rt_idx];
        opd <= regs[rd_idx];
      end
      S_EXECUTE: begin
        alu_q  <= alu_y;
        take_q <= (op == OP_JMP) || ((op == OP_BZ) && (opd == '0));
      end
      default: ;
    endcase
  end

  // Control FSM, program counter, register file and result.
  // Register writes land at the end of WRITEBACK, so the next instruction's
  // DECODE reads the updated value without any forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
          end
        end
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          if (op == OP_HALT) begin
            state <= S_HALT;
          end else begin
            state <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          state <= S_FETCH;
          pc    <= take_q ? tgt : pc + 1'b1;
          if (op_writes_reg(op)) begin
            regs[rd_idx] <= alu_q;
            result       <= alu_q;
            result_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
